// File: rtl/rf_wport_arbiter_if.sv
// rf_wport_arbiter_if
// Bundles the writeback, debug-write and register-file write-port signals
// that pass through rf_wport_arbiter. The "slave" modport is the arbiter's
// view; the "master" modport is the view of whatever surrounds it (the
// pipeline, the debug unit and the register file).

interface rf_wport_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int AR_BITS = 5
);

    logic               wb_we_i;
    logic [AR_BITS-1:0] wb_dst_i;
    logic [XLEN-1:0]    wb_r_i;

    logic               dbg_req_i;
    logic               dbg_rdy_o;
    logic [AR_BITS-1:0] dbg_addr_i;
    logic [XLEN-1:0]    dbg_wdata_i;
    logic               dbg_done_o;

    logic               rf_we_o;
    logic [AR_BITS-1:0] rf_dst_o;
    logic [XLEN-1:0]    rf_wdata_o;

    logic               pipe_stall_o;

    modport master (
        output wb_we_i, wb_dst_i, wb_r_i,
        output dbg_req_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_rdy_o, dbg_done_o,
        input  rf_we_o, rf_dst_o, rf_wdata_o,
        input  pipe_stall_o
    );

    modport slave (
        input  wb_we_i, wb_dst_i, wb_r_i,
        input  dbg_req_i, dbg_addr_i, dbg_wdata_i,
        output dbg_rdy_o, dbg_done_o,
        output rf_we_o, rf_dst_o, rf_wdata_o,
        output pipe_stall_o
    );

endinterface

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
// Shares the integer register file's single write port between the pipeline
// writeback stage (always wins, zero latency) and a buffered debug write that
// issues in the first cycle the port is free.
// Optional feature macro: RF_WARB_STARVE_EN. When defined, a saturating
// blocked-cycle counter moves a starved debug write into a STALL state that
// freezes the pipeline front-end via pipe_stall_o. When undefined, the debug
// write simply waits for a WB-free cycle and pipe_stall_o is tied low.

module rf_wport_arbiter #(
    parameter int XLEN         = 32,
    parameter int AR_BITS      = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_wport_arbiter_if.slave   bus
);

    // Reject out-of-range limits at elaboration time
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
        $error("rf_wport_arbiter: STARVE_LIMIT must be within 1..255");
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
`ifdef RF_WARB_STARVE_EN
    localparam logic [1:0] STALL = 2'd2;
    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);
`endif

    logic [1:0]         state_q, state_d;
    logic [AR_BITS-1:0] hold_addr_q, hold_addr_d;
    logic [XLEN-1:0]    hold_data_q, hold_data_d;

    logic wb_we;
    logic capture;
    logic issue;

    // A WB write to x0 is discarded and never occupies the port
    assign wb_we   = bus.wb_we_i && (bus.wb_dst_i != '0);
    assign capture = bus.dbg_req_i && (state_q == IDLE);
    assign issue   = (state_q != IDLE) && !wb_we;

`ifdef RF_WARB_STARVE_EN
    logic [7:0] cnt_q, cnt_d;

    // Blocked-cycle counter: cleared when a request is captured, saturating while blocked
    always_comb begin
        cnt_d = cnt_q;
        if (capture) begin
            cnt_d = 8'd0;
        end else if ((state_q == PEND) && wb_we && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state and hold-buffer logic for the pending debug write
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d     = PEND;
                    hold_addr_d = bus.dbg_addr_i;
                    hold_data_d = bus.dbg_wdata_i;
                end
            end
            PEND: begin
                if (!wb_we) begin
                    state_d = IDLE;
`ifdef RF_WARB_STARVE_EN
                end else if (cnt_q == LIMIT_M1) begin
                    state_d = STALL;
`endif
                end
            end
`ifdef RF_WARB_STARVE_EN
            STALL: begin
                if (!wb_we) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and hold registers; reset discards any pending debug write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Write-port mux: WB passes straight through unless the buffered debug write issues
    always_comb begin
        bus.rf_we_o    = 1'b0;
        bus.rf_dst_o   = '0;
        bus.rf_wdata_o = '0;
        bus.dbg_done_o = 1'b0;
        if (rst_n) begin
            if (issue) begin
                bus.rf_we_o    = (hold_addr_q != '0);
                bus.rf_dst_o   = hold_addr_q;
                bus.rf_wdata_o = hold_data_q;
                bus.dbg_done_o = 1'b1;
            end else begin
                bus.rf_we_o    = wb_we;
                bus.rf_dst_o   = bus.wb_dst_i;
                bus.rf_wdata_o = bus.wb_r_i;
            end
        end
    end

    // Handshake ready and front-end freeze request
    always_comb begin
        bus.dbg_rdy_o = (state_q == IDLE);
`ifdef RF_WARB_STARVE_EN
        bus.pipe_stall_o = rst_n && (state_q == STALL) && wb_we;
`else
        bus.pipe_stall_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter
// Self-checking bench for rf_wport_arbiter. A behavioural model tracks
// "is a debug write pending, what is it, how many cycles has it been blocked"
// and predicts every output; a compare process checks the DUT on each falling
// edge. Directed scenarios add literal expectations, then a long randomized
// run exercises bursts, x0 writes, back-to-back requests and mid-run resets.
// The starvation checks follow RF_WARB_STARVE_EN the same way the design does.

module tb_rf_wport_arbiter;

    localparam int XLEN = 32;
    localparam int AR   = 5;
    localparam int L    = 8;

`ifdef RF_WARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rf_wport_arbiter_if #(.XLEN(XLEN), .AR_BITS(AR)) bus ();

    rf_wport_arbiter #(
        .XLEN(XLEN),
        .AR_BITS(AR),
        .STARVE_LIMIT(L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: one pending debug write plus a count of blocked cycles
    bit              mPending;
    logic [AR-1:0]   mAddr;
    logic [XLEN-1:0] mData;
    int              mBlocked;

    logic wbEff;
    assign wbEff = bus.wb_we_i && (bus.wb_dst_i != '0);

    // Model update on each clock edge, discarded by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPending <= 1'b0;
            mAddr    <= '0;
            mData    <= '0;
            mBlocked <= 0;
        end else if (!mPending) begin
            if (bus.dbg_req_i) begin
                mPending <= 1'b1;
                mAddr    <= bus.dbg_addr_i;
                mData    <= bus.dbg_wdata_i;
                mBlocked <= 0;
            end
        end else if (wbEff) begin
            mBlocked <= mBlocked + 1;
        end else begin
            mPending <= 1'b0;
        end
    end

    logic            expRdy, expDone, expWe, expStall;
    logic [AR-1:0]   expDst;
    logic [XLEN-1:0] expData;

    // Expected outputs from the model state and the current inputs
    always_comb begin
        expRdy   = 1'b1;
        expDone  = 1'b0;
        expWe    = 1'b0;
        expDst   = '0;
        expData  = '0;
        expStall = 1'b0;
        if (rst_n) begin
            expRdy = !mPending;
            if (mPending && !wbEff) begin
                expDone = 1'b1;
                expWe   = (mAddr != '0);
                expDst  = mAddr;
                expData = mData;
            end else begin
                expWe    = wbEff;
                expDst   = bus.wb_dst_i;
                expData  = bus.wb_r_i;
                expStall = STARVE && mPending && (mBlocked >= L);
            end
        end
    end

    // Register-file image built from the write port, for final-value checks
    logic [XLEN-1:0] rfImage [32];
    always @(posedge clk) begin
        if (rst_n && bus.rf_we_o) begin
            rfImage[bus.rf_dst_o] <= bus.rf_wdata_o;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        checkOutput("dbg_rdy_o",    32'(bus.dbg_rdy_o),    32'(expRdy));
        checkOutput("dbg_done_o",   32'(bus.dbg_done_o),   32'(expDone));
        checkOutput("rf_we_o",      32'(bus.rf_we_o),      32'(expWe));
        checkOutput("rf_dst_o",     32'(bus.rf_dst_o),     32'(expDst));
        checkOutput("rf_wdata_o",   bus.rf_wdata_o,        expData);
        checkOutput("pipe_stall_o", 32'(bus.pipe_stall_o), 32'(expStall));
    end

    task automatic applyStimulus(input logic we, input logic [AR-1:0] dst, input logic [XLEN-1:0] r,
                                 input logic req, input logic [AR-1:0] addr, input logic [XLEN-1:0] wdata);
        bus.wb_we_i     = we;
        bus.wb_dst_i    = dst;
        bus.wb_r_i      = r;
        bus.dbg_req_i   = req;
        bus.dbg_addr_i  = addr;
        bus.dbg_wdata_i = wdata;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rdy"},   32'(bus.dbg_rdy_o),    32'd1);
        checkOutput({tag, " done"},  32'(bus.dbg_done_o),   32'd0);
        checkOutput({tag, " we"},    32'(bus.rf_we_o),      32'd0);
        checkOutput({tag, " dst"},   32'(bus.rf_dst_o),     32'd0);
        checkOutput({tag, " wdata"}, bus.rf_wdata_o,        32'd0);
        checkOutput({tag, " stall"}, 32'(bus.pipe_stall_o), 32'd0);
    endtask

    bit reqActive;
    bit lastAccept;
    bit burst;

    initial begin
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset values hold even with a WB write presented
        #2;
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
        #1;
        checkResetValues("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // WB passthrough in the same cycle
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
        #2;
        checkOutput("wb pass we",    32'(bus.rf_we_o),  32'd1);
        checkOutput("wb pass dst",   32'(bus.rf_dst_o), 32'd5);
        checkOutput("wb pass wdata", bus.rf_wdata_o,    32'h1234);

        // Debug write with WB idle: accepted at edge N, written in cycle N+1
        stepCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF);
        #2;
        checkOutput("dbg rdy before", 32'(bus.dbg_rdy_o), 32'd1);
        stepCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        checkOutput("dbg we",    32'(bus.rf_we_o),    32'd1);
        checkOutput("dbg dst",   32'(bus.rf_dst_o),   32'd7);
        checkOutput("dbg wdata", bus.rf_wdata_o,      32'hDEADBEEF);
        checkOutput("dbg done",  32'(bus.dbg_done_o), 32'd1);
        checkOutput("dbg rdy in write", 32'(bus.dbg_rdy_o), 32'd0);
        stepCycle();
        checkOutput("dbg rdy after", 32'(bus.dbg_rdy_o),  32'd1);
        checkOutput("dbg done after", 32'(bus.dbg_done_o), 32'd0);

        // Collision on x3: two WB writes land first, debug value lands last
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'h22);
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
            #2;
            checkOutput("coll wb wdata", bus.rf_wdata_o,      32'h11);
            checkOutput("coll wb done",  32'(bus.dbg_done_o), 32'd0);
            stepCycle();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        checkOutput("coll dbg dst",   32'(bus.rf_dst_o),   32'd3);
        checkOutput("coll dbg wdata", bus.rf_wdata_o,      32'h22);
        checkOutput("coll dbg done",  32'(bus.dbg_done_o), 32'd1);
        stepCycle();
        checkOutput("coll final x3", rfImage[3], 32'h22);

        // WB write to x0 does not block a pending debug write
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h55);
        stepCycle();
        applyStimulus(1'b1, 5'd0, 32'h99, 1'b0, '0, '0);
        #2;
        checkOutput("x0wb done",  32'(bus.dbg_done_o), 32'd1);
        checkOutput("x0wb we",    32'(bus.rf_we_o),    32'd1);
        checkOutput("x0wb dst",   32'(bus.rf_dst_o),   32'd9);
        checkOutput("x0wb wdata", bus.rf_wdata_o,      32'h55);

        // Debug write to x0 completes without enabling the port
        stepCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h77);
        stepCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        checkOutput("x0dbg we",   32'(bus.rf_we_o),    32'd0);
        checkOutput("x0dbg done", 32'(bus.dbg_done_o), 32'd1);
        stepCycle();

        // Starvation: stall only after L blocked cycles, drops with dbg_done_o
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 32'hABCD);
        stepCycle();
        for (int i = 1; i <= L; i++) begin
            applyStimulus(1'b1, 5'd6, 32'(i), 1'b0, '0, '0);
            #2;
            checkOutput("starve early stall", 32'(bus.pipe_stall_o), 32'd0);
            stepCycle();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd6, 32'h100 + 32'(i), 1'b0, '0, '0);
            #2;
            checkOutput("starve stall", 32'(bus.pipe_stall_o), 32'(STARVE));
            checkOutput("starve done",  32'(bus.dbg_done_o),   32'd0);
            stepCycle();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        checkOutput("starve release done",  32'(bus.dbg_done_o),   32'd1);
        checkOutput("starve release stall", 32'(bus.pipe_stall_o), 32'd0);
        checkOutput("starve release dst",   32'(bus.rf_dst_o),     32'd4);
        checkOutput("starve release wdata", bus.rf_wdata_o,        32'hABCD);
        stepCycle();

        // Reset while starved: outputs clear at once, pending write is dropped
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd12, 32'h5A5A);
        stepCycle();
        for (int i = 0; i < L + 2; i++) begin
            applyStimulus(1'b1, 5'd6, 32'h200, 1'b0, '0, '0);
            stepCycle();
        end
        checkOutput("pre-reset stall", 32'(bus.pipe_stall_o), 32'(STARVE));
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("async reset");
        stepCycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput("post-reset done", 32'(bus.dbg_done_o), 32'd0);
            stepCycle();
        end

        // Randomized traffic: bursts, x0 targets, held requests, rare resets
        reqActive  = 1'b0;
        lastAccept = 1'b0;
        burst      = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end
            if (lastAccept) begin
                reqActive = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) begin
                burst = !burst;
            end
            if (burst) begin
                bus.wb_we_i  = 1'b1;
                bus.wb_dst_i = AR'($urandom_range(1, 31));
            end else begin
                bus.wb_we_i  = 1'($urandom_range(0, 1));
                bus.wb_dst_i = AR'($urandom_range(0, 31));
            end
            bus.wb_r_i = $urandom;
            if (!reqActive && ($urandom_range(0, 2) == 0)) begin
                reqActive       = 1'b1;
                bus.dbg_addr_i  = ($urandom_range(0, 7) == 0) ? '0 : AR'($urandom_range(1, 31));
                bus.dbg_wdata_i = $urandom;
            end
            bus.dbg_req_i = reqActive;
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
            end
            @(negedge clk);
            lastAccept = reqActive && !mPending && rst_n;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
